// File: rtl/eth_arb_pkg.sv
// Shared types for the two-port Ethernet receive arbiter.
// Optional drop counters are enabled by ETH_ARB_DROP_CNT_EN.
package eth_arb_pkg;

  typedef enum logic {PORT0, PORT1} port_t;

  typedef enum logic {SERVED_P0, SERVED_P1} arb_state_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/port_byte_buffer.sv
// Per-port byte buffer: circular store with registered full flag.
// A push is judged against the count at the start of the cycle.
module port_byte_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic              accept;
  logic              pop_ok;

  assign accept = push && (count < (AW+1)'(DEPTH));
  assign drop   = push && !accept;
  assign pop_ok = pop && (count != '0);
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  assign count_nxt = count + (AW+1)'(accept)
                   - (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/eth_port_arbiter.sv
// Round-robin merge of two channel byte streams into one FIFO port.
// ETH_ARB_DROP_CNT_EN enables the saturating per-port drop counters.
module eth_port_arbiter
  import eth_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              p0_w_enable,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_w_enable,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p0_full,
  output logic              p1_full,
  input  logic              fifo_full,
  output logic              fifo_w_enable,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_port,
  output logic [7:0]        p0_drop_cnt,
  output logic [7:0]        p1_drop_cnt
);

  arb_state_t        state;
  port_t             grant;
  logic              grant_valid;
  logic              empty0, empty1;
  logic              drop0, drop1;
  logic              pop0, pop1;
  logic [DATA_W-1:0] head0, head1;

  port_byte_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf0 (
    .clk(clk), .n_rst(n_rst),
    .push(p0_w_enable), .push_data(p0_data),
    .pop(pop0), .head(head0),
    .empty(empty0), .full(p0_full), .drop(drop0)
  );

  port_byte_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf1 (
    .clk(clk), .n_rst(n_rst),
    .push(p1_w_enable), .push_data(p1_data),
    .pop(pop1), .head(head1),
    .empty(empty1), .full(p1_full), .drop(drop1)
  );

  always_comb begin
    grant_valid = 1'b1;
    grant       = PORT0;
    unique case (1'b1)
      (!empty0 && !empty1):
        grant = (state == SERVED_P0) ? PORT1 : PORT0;
      (!empty0 && empty1): grant = PORT0;
      (empty0 && !empty1): grant = PORT1;
      default: grant_valid = 1'b0;
    endcase
  end

  assign fifo_w_enable = grant_valid && !fifo_full;
  assign pop0 = fifo_w_enable && (grant == PORT0);
  assign pop1 = fifo_w_enable && (grant == PORT1);

  // Idle outputs read as zero so the reset view is clean
  assign fifo_port = grant_valid && (grant == PORT1);
  assign fifo_data = !grant_valid ? '0
                   : (grant == PORT1) ? head1 : head0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= SERVED_P1;
    end else if (fifo_w_enable) begin
      state <= (grant == PORT1) ? SERVED_P1 : SERVED_P0;
    end
  end

`ifdef ETH_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt0, drop_cnt1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_cnt0 <= '0;
      drop_cnt1 <= '0;
    end else begin
      if (drop0 && drop_cnt0 != DROP_CNT_MAX)
        drop_cnt0 <= drop_cnt0 + 8'd1;
      if (drop1 && drop_cnt1 != DROP_CNT_MAX)
        drop_cnt1 <= drop_cnt1 + 8'd1;
    end
  end

  assign p0_drop_cnt = drop_cnt0;
  assign p1_drop_cnt = drop_cnt1;
`else
  logic unused_drop;
  assign unused_drop = drop0 ^ drop1;
  assign p0_drop_cnt = '0;
  assign p1_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_port_arbiter.sv
// Scoreboard bench for eth_port_arbiter: per-port expected queues,
// round-robin prediction and directed boundary checks.
module tb_eth_port_arbiter;

  localparam int DEPTH = 4;
`ifdef ETH_ARB_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic       p0_w_enable, p1_w_enable;
  logic [7:0] p0_data, p1_data;
  logic       p0_full, p1_full;
  logic       fifo_full;
  logic       fifo_w_enable;
  logic [7:0] fifo_data;
  logic       fifo_port;
  logic [7:0] p0_drop_cnt, p1_drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] wlog[$];
  bit         last;
  int         md0, md1;

  always #5 clk = ~clk;

  eth_port_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .p0_w_enable(p0_w_enable), .p0_data(p0_data),
    .p1_w_enable(p1_w_enable), .p1_data(p1_data),
    .p0_full(p0_full), .p1_full(p1_full),
    .fifo_full(fifo_full), .fifo_w_enable(fifo_w_enable),
    .fifo_data(fifo_data), .fifo_port(fifo_port),
    .p0_drop_cnt(p0_drop_cnt), .p1_drop_cnt(p1_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void mgrant(output bit gv, output bit gp);
    gv = (q0.size() != 0) || (q1.size() != 0);
    if (q0.size() != 0 && q1.size() != 0) gp = ~last;
    else gp = (q0.size() == 0);
  endfunction

  // Model state advance: pops judged before pushes, pushes vs old count
  always @(posedge clk or negedge n_rst) begin
    bit gv, gp;
    int sz0, sz1;
    if (!n_rst) begin
      q0.delete(); q1.delete();
      last = 1'b1; md0 = 0; md1 = 0;
    end else begin
      sz0 = q0.size(); sz1 = q1.size();
      mgrant(gv, gp);
      if (gv && !fifo_full) begin
        if (gp) void'(q1.pop_front());
        else void'(q0.pop_front());
        last = gp;
      end
      if (p0_w_enable) begin
        if (sz0 < DEPTH) q0.push_back(p0_data);
        else if (md0 < 255) md0++;
      end
      if (p1_w_enable) begin
        if (sz1 < DEPTH) q1.push_back(p1_data);
        else if (md1 < 255) md1++;
      end
    end
  end

  always @(negedge clk) begin
    bit gv, gp;
    if (n_rst) begin
      mgrant(gv, gp);
      chk("wen", fifo_w_enable, gv && !fifo_full);
      if (gv && !fifo_full) begin
        chk("port", fifo_port, gp);
        chk("data", fifo_data, gp ? q1[0] : q0[0]);
        wlog.push_back({fifo_port, fifo_data});
      end
      chk("p0_full", p0_full, q0.size() == DEPTH);
      chk("p1_full", p1_full, q1.size() == DEPTH);
      chk("p0_drop", p0_drop_cnt, DROP_EN ? md0 : 0);
      chk("p1_drop", p1_drop_cnt, DROP_EN ? md1 : 0);
    end
  end

  task automatic step(input bit e0, input logic [7:0] d0,
                      input bit e1, input logic [7:0] d1,
                      input bit ff);
    p0_w_enable = e0; p0_data = d0;
    p1_w_enable = e1; p1_data = d1;
    fifo_full = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ff);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, ff);
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    #1;
    chk("rst_wen", fifo_w_enable, 0);
    chk("rst_p0_full", p0_full, 0);
    chk("rst_p1_full", p1_full, 0);
    chk("rst_p0_drop", p0_drop_cnt, 0);
    chk("rst_p1_drop", p1_drop_cnt, 0);
    chk("rst_port", fifo_port, 0);
    chk("rst_data", fifo_data, 0);
    p0_w_enable = 0; p1_w_enable = 0; fifo_full = 0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    logic [8:0] exp_order[6];
    logic [7:0] drop_before;
    exp_order = '{9'h001, 9'h111, 9'h002, 9'h112, 9'h003, 9'h113};
    n_rst = 1'b0;
    p0_w_enable = 0; p1_w_enable = 0;
    p0_data = 0; p1_data = 0; fifo_full = 0;
    @(posedge clk);
    #1;
    pulse_reset();

    // reset while both buffers hold bytes
    step(1, 8'hC1, 1, 8'hD1, 1);
    step(1, 8'hC2, 1, 8'hD2, 1);
    pulse_reset();
    idle(3, 0);
    chk("post_rst_wen", fifo_w_enable, 0);

    // single byte latency
    step(1, 8'hA5, 0, 8'h00, 0);
    chk("a5_wen", fifo_w_enable, 1);
    chk("a5_data", fifo_data, 8'hA5);
    chk("a5_port", fifo_port, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    chk("a5_after", fifo_w_enable, 0);

    // round-robin interleave
    pulse_reset();
    for (int i = 1; i <= 3; i++)
      step(1, 8'(i), 1, 8'(8'h10 + i), 1);
    wlog.delete();
    idle(8, 0);
    chk("rr_count", wlog.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < wlog.size()) chk("rr_order", wlog[i], exp_order[i]);

    // overflow on port 1
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 1, 8'(8'h40 + i), 1);
      if (i == 3) chk("p1_full_4th", p1_full, 1);
    end
    chk("p1_drop2", p1_drop_cnt, DROP_EN ? 2 : 0);
    idle(6, 0);

    // push into full buffer while it pops
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h60 + i), 0, 8'h00, 1);
    drop_before = p0_drop_cnt;
    step(1, 8'h77, 0, 8'h00, 0);
    chk("pp_full", p0_full, 0);
    chk("pp_drop", p0_drop_cnt, DROP_EN ? drop_before + 8'd1 : 8'd0);
    idle(6, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
           8'($urandom), ($urandom_range(0, 3) == 0));
    idle(10, 0);

    // drop counter saturation
    pulse_reset();
    for (int i = 0; i < DEPTH + 260; i++) step(1, 8'(i), 0, 8'h00, 1);
    chk("sat", p0_drop_cnt, DROP_EN ? 8'hFF : 8'h00);
    idle(6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_port_arbiter.md
Name: eth_port_arbiter

Overview:
- Shares one downstream receive FIFO write port between two Ethernet packet-processor channels (port 0, port 1).
- Each channel's decoded byte and write strobe are captured into a small per-port buffer.
- A round-robin scheduler drains the buffers into the shared FIFO, honouring its full flag.
- Drives each channel's FULL input so the channels self-throttle; tags every written byte with its source port.

Parameters:
- DEPTH, 4, entries per port buffer; power of two, >= 2
- DATA_W, 8, byte width

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- p0_w_enable  input  1  port 0 byte strobe, one cycle per byte
- p0_data  input  DATA_W  port 0 byte, valid with p0_w_enable
- p1_w_enable  input  1  port 1 byte strobe
- p1_data  input  DATA_W  port 1 byte
- p0_full  output  1  port 0 buffer full; drives channel 0 FULL
- p1_full  output  1  port 1 buffer full; drives channel 1 FULL
- fifo_full  input  1  shared FIFO full
- fifo_w_enable  output  1  shared FIFO write strobe
- fifo_data  output  DATA_W  byte written
- fifo_port  output  1  source port of fifo_data
- p0_drop_cnt  output  8  bytes dropped on port 0, saturating
- p1_drop_cnt  output  8  bytes dropped on port 1, saturating

Behaviour:
- Reset, asynchronous, n_rst low:
  - Both buffers are emptied (pointers and counts = 0).
  - last_grant = PORT1, so port 0 wins first.
  - Drop counters = 0.
  - Outputs: p0_full = 0, p1_full = 0, fifo_w_enable = 0, fifo_port = 0, fifo_data = 0.
- Push:
  - A strobe is accepted if the port's count < DEPTH at the start of the cycle. This holds even if a pop occurs in the same cycle.
  - An accepted byte is written at the head-relative tail on the rising edge.
  - A strobe while the count == DEPTH is dropped. The drop counter increments and saturates at 255.
- pN_full:
  - Registered; equals (count == DEPTH).
  - Rises the cycle after the filling push.
  - Falls the cycle after the pop that frees an entry.
- Scheduler, 2-state FSM on last_grant (SERVED_P0, SERVED_P1):
  - Eligible port = non-empty buffer.
  - Both eligible: grant the port that is not last_grant.
  - One eligible: grant it.
  - None eligible: no grant; state holds.
- Write:
  - fifo_w_enable = grant_valid & !fifo_full, combinational from registered state and fifo_full.
  - fifo_data = granted buffer head; fifo_port = granted port.
  - When fifo_w_enable is high, the granted buffer pops on that edge and last_grant updates to the granted port.
  - When fifo_full is high, there is no pop and no state change; fifo_data and fifo_port still show the candidate. Downstream treats them as don't-care when strobe = 0.
- Latency: a byte strobed in cycle N is written to the FIFO no earlier than cycle N+1.
- Throughput: at most one FIFO write per cycle, total across both ports.
- Order: per-port byte order is preserved. Interleaving between ports is byte-granular.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Simultaneous push and pop on the same port: count is unchanged and both take effect. On an empty buffer, a push is not visible to the scheduler until the next cycle; there is no bypass.
- Reset mid-operation discards all buffered bytes. No partial write follows reset release.

Optional Feature:
- Macro: ETH_ARB_DROP_CNT_EN.
- Defined: drop counters are implemented as described.
- Undefined: the counter registers are omitted, p0_drop_cnt and p1_drop_cnt are tied to 0, and drops still occur silently.

Decomposition:
- Package eth_arb_pkg holds:
  - typedef enum logic {PORT0, PORT1} port_t
  - typedef enum logic {SERVED_P0, SERVED_P1} arb_state_t
  - localparam DROP_CNT_MAX = 8'hFF
- Sub-module port_byte_buffer (parameters DEPTH, DATA_W; ports push, push_data, pop, head, empty, full, drop):
  - Instantiated once per port.
  - The arbiter top holds only the FSM, output muxing and drop counters.

Test Plan:
- Reset with n_rst low while both buffers hold bytes -> fifo_w_enable = 0, p0_full = p1_full = 0, drop counts 0 immediately; no write after release.
- Port 0 strobes 8'hA5, fifo_full = 0 -> next cycle fifo_w_enable = 1, fifo_data = 8'hA5, fifo_port = 0; following cycle strobe 0.
- Both ports load 3 bytes (p0: 01, 02, 03; p1: 11, 12, 13) while fifo_full = 1, then release -> writes 01, 11, 02, 12, 03, 13 on consecutive cycles with fifo_port alternating 0, 1.
- fifo_full = 1, port 1 strobes 6 bytes with DEPTH = 4 -> p1_full = 1 after the 4th; bytes 5 and 6 dropped; p1_drop_cnt = 2 (0 without ETH_ARB_DROP_CNT_EN).
- Buffer full and pop in the same cycle as a push on that port -> push dropped, count becomes DEPTH-1, drop count +1.
- Drop counter at 255 plus one further dropped strobe -> p0_drop_cnt stays 8'hFF.
